ibex_counter_access: RTL and testbench
======================================

Name: ibex_counter_access

Overview:
- 32-bit register-access front end that drives an ibex 64-bit counter's write and increment inputs and reads back its value.
- Gives a 32-bit bus three things:
  - coherent 64-bit reads, via a high-half snapshot taken when the low half is read;
  - split low/high writes;
  - an inhibit control that gates the counter's increment event.
- Sits between a CSR/peripheral bus and one counter instance.

Parameters:
- CounterWidth, 64, implemented counter bits (33..64); read data bits at or above CounterWidth return 0.
- ResetInhibit, 1'b0, reset value of the CTRL.inhibit bit.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active high
- req_i  in  1  bus request
- we_i  in  1  1 = write, 0 = read
- addr_i  in  2  0 = LO, 1 = HI, 2 = CTRL, 3 = invalid
- wdata_i  in  32  write data
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  response valid (one-cycle pulse)
- rdata_o  out  32  read data, valid with rvalid_o
- err_o  out  1  error response, valid with rvalid_o
- event_i  in  1  raw count event
- counter_inc_o  out  1  increment strobe to counter
- counter_we_o  out  1  low-half write strobe
- counterh_we_o  out  1  high-half write strobe
- counter_wval_o  out  32  write value to counter
- counter_val_i  in  64  current counter value

Behaviour:
- Reset: all registered outputs are 0 (rvalid_o, rdata_o, err_o, counter_we_o, counterh_we_o, counter_wval_o); shadow_q = 0, shadow_vld_q = 0, inhibit_q = ResetInhibit; FSM in IDLE.
- FSM has two states:
  - IDLE: gnt_o = req_i. On a grant, capture the access and go to RESP.
  - RESP: gnt_o = 0. rvalid_o = 1 for exactly one cycle, then IDLE. So there is at most one outstanding access and back-to-back grants are 2 cycles apart.
- Read latency: grant in cycle N, rvalid_o/rdata_o in cycle N+1. Read data is sampled from counter_val_i in cycle N (the grant cycle), not in N+1.
- Read LO:
  - rdata = counter_val_i[31:0] from the grant cycle;
  - the same cycle loads shadow_q <= counter_val_i[63:32] and sets shadow_vld_q.
- Read HI:
  - rdata = shadow_q if shadow_vld_q, else live counter_val_i[63:32];
  - always clears shadow_vld_q.
- Read CTRL: rdata = {31'b0, inhibit_q}, plus the overflow bit when the optional feature is enabled.
- Write LO: in cycle N+1, counter_we_o = 1 and counter_wval_o = wdata_i captured at grant. Clears shadow_vld_q.
- Write HI: same as Write LO but asserts counterh_we_o. Clears shadow_vld_q.
- Write CTRL: inhibit_q <= wdata_i[0], visible from cycle N+1.
- Write strobes are single-cycle and coincide with rvalid_o. Writes return rdata_o = 0.
- addr 3 (read or write): err_o = 1 with rvalid_o, rdata_o = 0, no side effects.
- counter_inc_o = event_i & ~inhibit_q & ~(counter_we_o | counterh_we_o). The increment is dropped, not deferred, in a write-strobe cycle.
- Width masking: bits of rdata_o at or above CounterWidth (relative to the 64-bit value) read 0. Writes are passed through unmasked.
- Wrap-around: no special handling; the counter itself wraps.
- Reset during RESP: rvalid_o and all strobes drop immediately (asynchronous); the pending response is lost.
- req_i held high across RESP is not granted until the next IDLE cycle.

Optional Feature:
- Macro: IBEX_COUNTER_ACCESS_OVF_EN.
- When defined:
  - adds a sticky CTRL bit 1, ovf_q;
  - ovf_q sets when counter_inc_o = 1 and counter_val_i masked to CounterWidth is all ones;
  - a CTRL write with wdata_i[1] = 1 clears it; set wins over a simultaneous clear;
  - adds output port ovf_irq_o (1 bit) = ovf_q.
- When undefined: CTRL bit 1 reads 0, writes to it are ignored, and the ovf_irq_o port does not exist.

Test Plan:
- Coherent read: counter_val_i = 64'h0000_0001_FFFF_FFFF during the LO read; counter then increments to 64'h0000_0002_0000_0000 before the HI read → LO returns 32'hFFFF_FFFF and HI returns 32'h0000_0001 (shadow).
- HI read with no preceding LO read, counter_val_i = 64'hABCD_0000_1234_5678 → rdata_o = 32'hABCD_0000. A second HI read returns the live value.
- Write LO 32'hDEAD_BEEF, grant in cycle N → in cycle N+1: counter_we_o = 1, counter_wval_o = 32'hDEAD_BEEF, rvalid_o = 1. event_i = 1 in that cycle gives counter_inc_o = 0.
- Write CTRL 1, then hold event_i = 1 for 5 cycles → counter_inc_o stays 0. Write CTRL 0 → counter_inc_o follows event_i from the next cycle.
- Access to addr 3, with we_i = 0 and with we_i = 1 → err_o = 1 and rvalid_o = 1 in cycle N+1, no strobes, CTRL unchanged.
- With IBEX_COUNTER_ACCESS_OVF_EN and CounterWidth = 40: counter_val_i = 64'h0000_00FF_FFFF_FFFF plus an event → ovf_irq_o = 1 next cycle. CTRL write 2'b10 clears it; a reset mid-RESP clears rvalid_o and ovf_q.

Source files
------------

// File: rtl/ibex_counter_access.sv
// 32-bit bus front end for a 64-bit ibex counter: coherent split reads, split writes, inhibit.
// Optional sticky overflow flag and interrupt enabled by IBEX_COUNTER_ACCESS_OVF_EN.
module ibex_counter_access #(
  parameter int unsigned CounterWidth = 64,
  parameter bit          ResetInhibit = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        event_i,
  output logic        counter_inc_o,
  output logic        counter_we_o,
  output logic        counterh_we_o,
  output logic [31:0] counter_wval_o,
`ifdef IBEX_COUNTER_ACCESS_OVF_EN
  output logic        ovf_irq_o,
`endif
  input  logic [63:0] counter_val_i
);

  localparam logic [64:0] CntMaskW = (65'd1 << CounterWidth) - 65'd1;
  localparam logic [63:0] CntMask  = CntMaskW[63:0];

  typedef enum logic {StIdle, StResp} state_e;

  state_e      state_q, state_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic        hwe_q, hwe_d;
  logic [31:0] wval_q, wval_d;
  logic [31:0] shadow_q, shadow_d;
  logic        shadow_vld_q, shadow_vld_d;
  logic        inhibit_q, inhibit_d;
  logic        ovf_q, ovf_d;
  logic [63:0] val_masked;
  logic [31:0] ctrl_rdata;

  assign val_masked = counter_val_i & CntMask;
  // Increments landing in a write-strobe cycle are dropped, not deferred.
  assign counter_inc_o = event_i & ~inhibit_q & ~(we_q | hwe_q);

`ifdef IBEX_COUNTER_ACCESS_OVF_EN
  assign ctrl_rdata = {30'b0, ovf_q, inhibit_q};
  assign ovf_irq_o  = ovf_q;

  always_comb begin
    ovf_d = ovf_q;
    if (gnt_o && we_i && (addr_i == 2'd2) && wdata_i[1]) ovf_d = 1'b0;
    if (counter_inc_o && (val_masked == CntMask)) ovf_d = 1'b1;
  end
`else
  assign ctrl_rdata = {31'b0, inhibit_q};
  assign ovf_d      = 1'b0;
`endif

  always_comb begin
    gnt_o        = (state_q == StIdle) & req_i;
    state_d      = gnt_o ? StResp : StIdle;
    rvalid_d     = gnt_o;
    rdata_d      = '0;
    err_d        = 1'b0;
    we_d         = 1'b0;
    hwe_d        = 1'b0;
    wval_d       = '0;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    inhibit_d    = inhibit_q;
    if (gnt_o) begin
      unique case (addr_i)
        2'd0: begin
          if (we_i) begin
            we_d         = 1'b1;
            wval_d       = wdata_i;
            shadow_vld_d = 1'b0;
          end else begin
            // Snapshot the high half so a following HI read is coherent with this LO read.
            rdata_d      = val_masked[31:0];
            shadow_d     = val_masked[63:32];
            shadow_vld_d = 1'b1;
          end
        end
        2'd1: begin
          shadow_vld_d = 1'b0;
          if (we_i) begin
            hwe_d  = 1'b1;
            wval_d = wdata_i;
          end else begin
            rdata_d = shadow_vld_q ? shadow_q : val_masked[63:32];
          end
        end
        2'd2: begin
          if (we_i) inhibit_d = wdata_i[0];
          else      rdata_d   = ctrl_rdata;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      we_q         <= 1'b0;
      hwe_q        <= 1'b0;
      wval_q       <= '0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      inhibit_q    <= ResetInhibit;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      we_q         <= we_d;
      hwe_q        <= hwe_d;
      wval_q       <= wval_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      inhibit_q    <= inhibit_d;
      ovf_q        <= ovf_d;
    end
  end

  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign err_o          = err_q;
  assign counter_we_o   = we_q;
  assign counterh_we_o  = hwe_q;
  assign counter_wval_o = wval_q;

endmodule

// File: tb/tb_ibex_counter_access.sv
// Directed plus randomized bench for ibex_counter_access against a register-level reference model.
module tb_ibex_counter_access;
`ifdef IBEX_COUNTER_ACCESS_OVF_EN
  localparam int unsigned CW = 40;
`else
  localparam int unsigned CW = 64;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, ev_in;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [63:0] cval;
  logic        gnt, rvalid, err, inc, cwe, chwe;
  logic [31:0] rdata, wval;
`ifdef IBEX_COUNTER_ACCESS_OVF_EN
  logic        ovf_irq;
`endif

  ibex_counter_access #(.CounterWidth(CW), .ResetInhibit(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .event_i(ev_in),
    .counter_inc_o(inc), .counter_we_o(cwe), .counterh_we_o(chwe), .counter_wval_o(wval),
`ifdef IBEX_COUNTER_ACCESS_OVF_EN
    .ovf_irq_o(ovf_irq),
`endif
    .counter_val_i(cval)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the architecturally visible registers only.
  logic [63:0] mask;
  logic [31:0] m_shadow;
  bit          m_vld, m_inh, m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_ones(input logic [63:0] v);
    return (v & mask) == mask;
  endfunction

  task automatic model_reset();
    m_shadow = '0;
    m_vld    = 1'b0;
    m_inh    = 1'b0;
    m_ovf    = 1'b0;
  endtask

  task automatic idle(input bit e, input logic [63:0] cv);
    bit exp_inc;
    @(negedge clk);
    req = 1'b0; ev_in = e; cval = cv;
    #1;
    exp_inc = e & ~m_inh;
    check("idle_inc", inc, exp_inc);
    check("idle_rvalid", rvalid, 1'b0);
`ifdef IBEX_COUNTER_ACCESS_OVF_EN
    check("idle_ovf", ovf_irq, m_ovf);
    if (exp_inc && all_ones(cv)) m_ovf = 1'b1;
`endif
  endtask

  task automatic access(input bit w, input logic [1:0] a, input logic [31:0] wd,
                        input logic [63:0] cv, input bit e);
    logic [63:0] masked;
    logic [31:0] exp_rdata;
    bit exp_inc, exp_err, exp_we, exp_hwe, clr;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = wd; cval = cv; ev_in = e;
    #1;
    check("gnt", gnt, 1'b1);
    exp_inc = e & ~m_inh;
    check("grant_inc", inc, exp_inc);
`ifdef IBEX_COUNTER_ACCESS_OVF_EN
    check("grant_ovf", ovf_irq, m_ovf);
`endif
    masked    = cv & mask;
    exp_rdata = '0;
    exp_err   = (a == 2'd3);
    exp_we    = w && (a == 2'd0);
    exp_hwe   = w && (a == 2'd1);
    clr       = w && (a == 2'd2) && wd[1];
    case (a)
      2'd0: if (w) m_vld = 1'b0;
            else begin exp_rdata = masked[31:0]; m_shadow = masked[63:32]; m_vld = 1'b1; end
      2'd1: begin
        if (!w) exp_rdata = m_vld ? m_shadow : masked[63:32];
        m_vld = 1'b0;
      end
      2'd2: if (w) m_inh = wd[0];
            else exp_rdata = {30'b0, m_ovf, m_inh};
      default: ;
    endcase
`ifdef IBEX_COUNTER_ACCESS_OVF_EN
    m_ovf = (m_ovf & ~clr) | (exp_inc & all_ones(cv));
`endif
    @(posedge clk);
    #1;
    check("rvalid", rvalid, 1'b1);
    check("rdata", rdata, exp_rdata);
    check("err", err, exp_err);
    check("counter_we", cwe, exp_we);
    check("counterh_we", chwe, exp_hwe);
    if (exp_we || exp_hwe) check("wval", wval, wd);
    check("resp_gnt", gnt, 1'b0);
    check("resp_inc", inc, e & ~m_inh & ~(exp_we | exp_hwe));
`ifdef IBEX_COUNTER_ACCESS_OVF_EN
    check("resp_ovf", ovf_irq, m_ovf);
`endif
    @(negedge clk);
    req = 1'b0; ev_in = 1'b0;
  endtask

  initial begin
    mask = (CW >= 64) ? '1 : ((64'd1 << CW) - 64'd1);
    model_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; cval = '0; ev_in = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", err, 1'b0);
    check("rst_we", cwe, 1'b0);
    check("rst_hwe", chwe, 1'b0);
    check("rst_wval", wval, 32'h0);
    check("rst_gnt", gnt, 1'b0);
    check("rst_inc", inc, 1'b1);
    @(negedge clk);
    rst = 1'b0; ev_in = 1'b0;

    // Coherent LO/HI read across a carry
    access(1'b0, 2'd0, '0, 64'h0000_0001_FFFF_FFFF, 1'b0);
    access(1'b0, 2'd1, '0, 64'h0000_0002_0000_0000, 1'b0);
    // HI read without a preceding LO read, then again (live)
    access(1'b0, 2'd1, '0, 64'hABCD_0000_1234_5678, 1'b0);
    access(1'b0, 2'd1, '0, 64'h1111_2222_3333_4444, 1'b0);
    // Writes; event during strobe cycle is dropped
    access(1'b1, 2'd0, 32'hDEAD_BEEF, 64'h5, 1'b1);
    access(1'b1, 2'd1, 32'hCAFE_F00D, 64'h6, 1'b1);
    // Inhibit
    access(1'b1, 2'd2, 32'h1, 64'h7, 1'b0);
    repeat (5) idle(1'b1, {$urandom, $urandom});
    access(1'b0, 2'd2, '0, 64'h8, 1'b1);
    access(1'b1, 2'd2, 32'h0, 64'h9, 1'b1);
    repeat (2) idle(1'b1, 64'h10);
    // Invalid address, read and write; CTRL must remain unchanged
    access(1'b0, 2'd3, '0, 64'h11, 1'b0);
    access(1'b1, 2'd3, 32'hFFFF_FFFF, 64'h12, 1'b0);
    access(1'b0, 2'd2, '0, 64'h13, 1'b0);
    // A write between LO and HI reads invalidates the snapshot
    access(1'b0, 2'd0, '0, 64'h0000_0003_0000_0001, 1'b0);
    access(1'b1, 2'd1, 32'h7, 64'h0000_0004_0000_0002, 1'b0);
    access(1'b0, 2'd1, '0, 64'h0000_0005_0000_0003, 1'b0);
`ifdef IBEX_COUNTER_ACCESS_OVF_EN
    idle(1'b1, 64'h0000_00FF_FFFF_FFFF);
    idle(1'b0, 64'h0);
    access(1'b0, 2'd2, '0, 64'h0, 1'b0);
    access(1'b1, 2'd2, 32'h2, 64'h0, 1'b0);
    idle(1'b0, 64'h0);
    idle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(1'b0, 64'h0);
`endif

    for (int i = 0; i < 80; i++) begin
      logic [63:0] cv;
      cv = ($urandom_range(0, 7) == 0) ? mask : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)), cv);
      else access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, cv,
                  1'($urandom_range(0, 1)));
    end

    // Reset while a write response is pending
    access(1'b1, 2'd2, 32'h0, 64'h0, 1'b0);
    idle(1'b1, mask);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'h1234_5678; ev_in = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_rvalid", rvalid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_rvalid", rvalid, 1'b0);
    check("mid_rst_we", cwe, 1'b0);
`ifdef IBEX_COUNTER_ACCESS_OVF_EN
    check("mid_rst_ovf", ovf_irq, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    model_reset();
    access(1'b0, 2'd2, '0, 64'h0, 1'b0);
    access(1'b0, 2'd1, '0, 64'h0000_0042_0000_0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
